// File: rtl/ctrl_unit_if.sv
// ctrl_unit_if: bus between the instruction sequencer and the 8-bit datapath.
// master = sequencer side (drives controls), slave = datapath side.
interface ctrl_unit_if;
   logic [15:0] instruction;
   logic        z;
   logic        c;
   logic [10:0] stack_addr;

   logic        insel;
   logic        we;
   logic        selpc;
   logic        selk;
   logic        ldpc;
   logic        ldflag;
   logic        selimm;
   logic        wr_en;
   logic        rd_en;
   logic [2:0]  raa;
   logic [2:0]  rab;
   logic [2:0]  wa;
   logic [2:0]  opalu;
   logic [2:0]  sh;
   logic [10:0] ninst_addr;
   logic [7:0]  kte;
   logic [7:0]  imm;
   logic [7:0]  port_addr;
   logic        port_rd;
   logic        port_wr;
   logic        halted;
   logic        stack_err;

   modport master (
      input  instruction, z, c, stack_addr,
      output insel, we, selpc, selk, ldpc, ldflag, selimm, wr_en, rd_en,
             raa, rab, wa, opalu, sh, ninst_addr, kte, imm, port_addr,
             port_rd, port_wr, halted, stack_err
   );

   modport slave (
      output instruction, z, c, stack_addr,
      input  insel, we, selpc, selk, ldpc, ldflag, selimm, wr_en, rd_en,
             raa, rab, wa, opalu, sh, ninst_addr, kte, imm, port_addr,
             port_rd, port_wr, halted, stack_err
   );
endinterface

// File: rtl/ctrl_unit.sv
// ctrl_unit: instruction sequencer for the 8-bit core. Latches the ROM word,
// decodes it and drives all datapath, stack and I/O controls each cycle.
// Optional macro CTRL_STEP_EN adds a 'step' input that gates each fetch.
module ctrl_unit #(
   parameter int unsigned STACK_DEPTH = 16,
   parameter logic [2:0]  OPALU_ADD   = 3'b000,
   parameter logic [2:0]  OPALU_SUB   = 3'b001,
   parameter logic [2:0]  OPALU_PASSA = 3'b110
) (
   input  logic        clk,
   input  logic        rst,
`ifdef CTRL_STEP_EN
   input  logic        step,
`endif
   ctrl_unit_if.master bus
);

   localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_HALT = 5'b00001;
   localparam logic [4:0] OP_LDI  = 5'b00010;
   localparam logic [4:0] OP_LDM  = 5'b00011;
   localparam logic [4:0] OP_STM  = 5'b00100;
   localparam logic [4:0] OP_ADI  = 5'b00101;
   localparam logic [4:0] OP_CMP  = 5'b00110;
   localparam logic [4:0] OP_SHF  = 5'b10000;
   localparam logic [4:0] OP_JMP  = 5'b11000;
   localparam logic [4:0] OP_JZ   = 5'b11001;
   localparam logic [4:0] OP_JNZ  = 5'b11010;
   localparam logic [4:0] OP_JC   = 5'b11011;
   localparam logic [4:0] OP_JNC  = 5'b11100;
   localparam logic [4:0] OP_CALL = 5'b11101;
   localparam logic [4:0] OP_RET  = 5'b11110;

   typedef enum logic [1:0] {FETCH, EXEC, MEMRD, HALT} state_t;

   state_t               r_state;
   logic [15:0]          r_ir;
   logic [DEPTH_W-1:0]   r_depth;
   logic                 r_stack_err;

   logic [4:0]  w_op;
   logic [2:0]  w_rd;
   logic [2:0]  w_rs;
   logic [7:0]  w_k;
   logic [10:0] w_a;
   logic        w_can_push;
   logic        w_can_pop;
   logic        w_step;

   logic        w_insel, w_we, w_selpc, w_selk, w_ldpc, w_ldflag, w_selimm;
   logic        w_wr_en, w_rd_en, w_port_rd, w_port_wr, w_halted;
   logic [2:0]  w_raa, w_rab, w_wa, w_opalu, w_sh;
   logic [10:0] w_ninst_addr;

   assign w_op       = r_ir[15:11];
   assign w_rd       = r_ir[10:8];
   assign w_rs       = r_ir[7:5];
   assign w_k        = r_ir[7:0];
   assign w_a        = r_ir[10:0];
   assign w_can_push = (r_depth < DEPTH_W'(STACK_DEPTH));
   assign w_can_pop  = (r_depth != '0);

`ifdef CTRL_STEP_EN
   assign w_step = step;
`else
   assign w_step = 1'b1;
`endif

   // Sequencer state, instruction register, call depth and sticky stack error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= FETCH;
         r_ir        <= '0;
         r_depth     <= '0;
         r_stack_err <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               if (w_step) begin
                  r_ir    <= bus.instruction;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_state <= FETCH;
               case (w_op)
                  OP_HALT: r_state <= HALT;
                  OP_LDM:  r_state <= MEMRD;
                  OP_CALL: begin
                     if (w_can_push) r_depth <= r_depth + DEPTH_W'(1);
                     else            r_stack_err <= 1'b1;
                  end
                  OP_RET: begin
                     if (w_can_pop) r_depth <= r_depth - DEPTH_W'(1);
                     else           r_stack_err <= 1'b1;
                  end
                  default: ;
               endcase
            end
            MEMRD:   r_state <= FETCH;
            HALT:    r_state <= HALT;
            default: r_state <= FETCH;
         endcase
      end
   end

   // Control decode from current state and latched instruction
   always_comb begin
      w_insel      = 1'b0;
      w_we         = 1'b0;
      w_selpc      = 1'b0;
      w_selk       = 1'b0;
      w_ldpc       = 1'b0;
      w_ldflag     = 1'b0;
      w_selimm     = 1'b0;
      w_wr_en      = 1'b0;
      w_rd_en      = 1'b0;
      w_port_rd    = 1'b0;
      w_port_wr    = 1'b0;
      w_halted     = 1'b0;
      w_raa        = 3'd0;
      w_rab        = 3'd0;
      w_wa         = 3'd0;
      w_opalu      = OPALU_ADD;
      w_sh         = 3'd0;
      w_ninst_addr = w_a;
      case (r_state)
         EXEC: begin
            w_ldpc = 1'b1;
            casez (w_op)
               OP_NOP: ;
               OP_HALT: begin
                  w_ldpc   = 1'b0;
                  w_halted = 1'b1;
               end
               OP_LDI: begin
                  w_selk = 1'b1;
                  w_we   = 1'b1;
                  w_wa   = w_rd;
               end
               OP_LDM: begin
                  w_port_rd = 1'b1;
                  w_ldpc    = 1'b0;
               end
               OP_STM: begin
                  w_raa     = w_rd;
                  w_opalu   = OPALU_PASSA;
                  w_port_wr = 1'b1;
               end
               OP_ADI: begin
                  w_raa    = w_rd;
                  w_selimm = 1'b1;
                  w_opalu  = OPALU_ADD;
                  w_insel  = 1'b1;
                  w_we     = 1'b1;
                  w_wa     = w_rd;
                  w_ldflag = 1'b1;
               end
               OP_CMP: begin
                  w_raa    = w_rd;
                  w_rab    = w_rs;
                  w_opalu  = OPALU_SUB;
                  w_ldflag = 1'b1;
               end
               5'b01???: begin
                  w_raa    = w_rd;
                  w_rab    = w_rs;
                  w_opalu  = w_op[2:0];
                  w_insel  = 1'b1;
                  w_we     = 1'b1;
                  w_wa     = w_rd;
                  w_ldflag = 1'b1;
               end
               OP_SHF: begin
                  w_raa   = w_rd;
                  w_opalu = OPALU_PASSA;
                  w_sh    = r_ir[2:0];
                  w_insel = 1'b1;
                  w_we    = 1'b1;
                  w_wa    = w_rd;
               end
               OP_JMP: w_selpc = 1'b1;
               OP_JZ:  w_selpc = bus.z;
               OP_JNZ: w_selpc = ~bus.z;
               OP_JC:  w_selpc = bus.c;
               OP_JNC: w_selpc = ~bus.c;
               OP_CALL: begin
                  // A full stack degrades CALL to a NOP; the error is latched.
                  w_wr_en = w_can_push;
                  w_selpc = w_can_push;
               end
               OP_RET: begin
                  // An empty stack degrades RET to a NOP; the error is latched.
                  w_rd_en = w_can_pop;
                  w_selpc = w_can_pop;
                  if (w_can_pop) w_ninst_addr = bus.stack_addr;
               end
               default: ;
            endcase
         end
         MEMRD: begin
            w_we   = 1'b1;
            w_wa   = w_rd;
            w_ldpc = 1'b1;
         end
         HALT:    w_halted = 1'b1;
         default: ;
      endcase
   end

   assign bus.insel      = w_insel;
   assign bus.we         = w_we;
   assign bus.selpc      = w_selpc;
   assign bus.selk       = w_selk;
   assign bus.ldpc       = w_ldpc;
   assign bus.ldflag     = w_ldflag;
   assign bus.selimm     = w_selimm;
   assign bus.wr_en      = w_wr_en;
   assign bus.rd_en      = w_rd_en;
   assign bus.raa        = w_raa;
   assign bus.rab        = w_rab;
   assign bus.wa         = w_wa;
   assign bus.opalu      = w_opalu;
   assign bus.sh         = w_sh;
   assign bus.ninst_addr = w_ninst_addr;
   assign bus.kte        = w_k;
   assign bus.imm        = w_k;
   assign bus.port_addr  = w_k;
   assign bus.port_rd    = w_port_rd;
   assign bus.port_wr    = w_port_wr;
   assign bus.halted     = w_halted;
   assign bus.stack_err  = r_stack_err;

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
- Instruction sequencer for the 8-bit core's datapath.
- Latches the 16-bit instruction word from program ROM and decodes it.
- Drives every datapath control per cycle: register file, ALU, shifter, PC, LIFO stack and immediate muxes, plus the I/O port read/write strobes.
- Consumes the z/c flags and stack return address from the datapath; no arithmetic of its own apart from the stack-depth counter.

Parameters:
- STACK_DEPTH, 16, LIFO entries; bounds the call-depth counter.
- OPALU_ADD, 3'b000, opalu code selecting A+B.
- OPALU_SUB, 3'b001, opalu code selecting A-B.
- OPALU_PASSA, 3'b110, opalu code passing A unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- instruction  in  16  ROM word at inst_addr, valid one cycle after PC changes.
- z  in  1  registered zero flag.
- c  in  1  registered carry flag.
- stack_addr  in  11  return address (LIFO top + 1).
- insel, we, selpc, selk, ldpc, ldflag, selimm, wr_en, rd_en  out  1 each  datapath controls.
- raa, rab, wa  out  3 each  register addresses.
- opalu  out  3  ALU operation.
- sh  out  3  shifter control; 3'b000 = no shift.
- ninst_addr  out  11  branch target.
- kte, imm  out  8 each  constant / immediate.
- port_addr  out  8  I/O address.
- port_rd, port_wr  out  1 each  I/O strobes.
- halted  out  1  core stopped.
- stack_err  out  1  sticky over/underflow flag.

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
- Reset state: FETCH; IR=0; depth counter=0; halted=0; stack_err=0.
- All strobes are 0 in reset and whenever not listed below.
- Outputs are decoded combinationally from state and IR.
- Field decode:
  - op = IR[15:11]; rd = IR[10:8]; rs = IR[7:5]; k = IR[7:0]; a = IR[10:0].
  - kte = imm = port_addr = k; ninst_addr = a, except for RET.
- FSM states: FETCH, EXEC, MEMRD, HALT.
- FETCH:
  - All strobes 0.
  - IR <= instruction.
  - Next state EXEC.
- EXEC: ldpc=1 for every op except LDM (see MEMRD) and HALT. Next state FETCH unless stated otherwise.
  - 00000 NOP: PC+1.
  - 00001 HALT: ldpc=0; next state HALT.
  - 00010 LDI: selk=1, insel=0, we=1, wa=rd.
  - 00011 LDM: port_rd=1, ldpc=0; next state MEMRD.
  - 00100 STM: raa=rd, opalu=OPALU_PASSA, sh=0, port_wr=1.
  - 00101 ADI: raa=rd, selimm=1, opalu=OPALU_ADD, insel=1, we=1, wa=rd, ldflag=1.
  - 00110 CMP: raa=rd, rab=rs, opalu=OPALU_SUB, ldflag=1, we=0.
  - 01xxx ALU: raa=rd, rab=rs, opalu=op[2:0], selimm=0, sh=0, insel=1, we=1, wa=rd, ldflag=1.
  - 10000 SHF: raa=rd, opalu=OPALU_PASSA, sh=IR[2:0], insel=1, we=1, wa=rd, ldflag=0.
  - 11000 JMP: selpc=1.
  - 11001 JZ: selpc=z.
  - 11010 JNZ: selpc=~z.
  - 11011 JC: selpc=c.
  - 11100 JNC: selpc=~c.
  - 11101 CALL:
    - If depth<STACK_DEPTH: wr_en=1, selpc=1, depth+1.
    - Else: no push, selpc=0 (acts as NOP), stack_err<=1.
  - 11110 RET:
    - If depth>0: rd_en=1, selpc=1, ninst_addr=stack_addr, depth-1.
    - Else: acts as NOP, stack_err<=1.
  - Any other opcode: NOP.
- MEMRD:
  - insel=0, selk=0, we=1, wa=rd, port_addr=k, ldpc=1.
  - Next state FETCH.
- Timing: LDM takes 3 cycles; all other instructions take 2.
- HALT:
  - halted=1; all strobes 0.
  - Exit only by reset.
- Strobe width: port_rd and port_wr are single-cycle. wr_en and rd_en are never asserted together.
- Reset mid-instruction aborts it. No partial register or stack write completes after rst rises.

Optional Feature:
- Macro: CTRL_STEP_EN adds input step (1 bit).
- With macro: FETCH holds (no IR load, all strobes 0) until step=1 is sampled. Each step pulse executes exactly one instruction; HALT is unchanged.
- Without macro: no step port; FETCH always advances after one cycle.

Test Plan:
- Reset, then ROM: LDI r1,0x05 / ADI r1,0x03 / HALT.
  - Required: we pulses at cycles 2 and 4 with wa=1; kte=0x05; imm=0x03, selimm=1, ldflag=1; halted=1 from cycle 6.
  - Required: ldpc never asserted after halted=1.
- CMP r2,r3 with z=1, then JZ 0x123.
  - Required: ldflag=1 with we=0 on CMP; JZ EXEC drives selpc=1, ninst_addr=0x123.
  - Repeat with z=0: selpc=0.
- LDM r4,[0x40].
  - Required: EXEC has port_rd=1, port_addr=0x40, ldpc=0; MEMRD has we=1, wa=4, insel=0, selk=0, ldpc=1; total 3 cycles.
- CALL 0x200 then RET with stack_addr=0x011.
  - Required: CALL drives wr_en=1, selpc=1, ninst_addr=0x200.
  - Required: RET drives rd_en=1, ninst_addr=0x011; stack_err=0.
- RET at depth 0.
  - Required: rd_en=0, selpc=0, ldpc=1, stack_err=1 sticky.
  - Then 17 CALLs with STACK_DEPTH=16: the 17th has wr_en=0, selpc=0.
- Assert rst during MEMRD.
  - Required: we=0 immediately, state FETCH, stack_err and halted cleared.
  - With CTRL_STEP_EN: FETCH holds until step=1, then exactly one instruction executes.
